// File: rtl/timer_pkg.sv
// Shared definitions for the APB compare timer: register map, bit positions,
// prescaler select encoding and small helpers.
package timer_pkg;

  // Register byte offsets
  localparam int unsigned REG_TCR  = 0;
  localparam int unsigned REG_TSR  = 1;
  localparam int unsigned REG_TIER = 2;
  localparam int unsigned REG_TDR  = 4;
  localparam int unsigned REG_TCMP = 8;
  localparam int unsigned REG_TCNT = 12;

  // TCR bit positions
  localparam int unsigned TCR_LOAD = 7;
  localparam int unsigned TCR_POL  = 6;
  localparam int unsigned TCR_DW   = 5;
  localparam int unsigned TCR_EN   = 4;
  localparam int unsigned TCR_CLR  = 3;

  // TSR bit positions
  localparam int unsigned TSR_OVF = 0;
  localparam int unsigned TSR_UDF = 1;
  localparam int unsigned TSR_CMP = 2;

  // Prescaler counter width (largest divisor is 16)
  localparam int unsigned PRE_W = 4;

  typedef enum logic [1:0] {
    CLK_DIV2  = 2'b00,
    CLK_DIV4  = 2'b01,
    CLK_DIV8  = 2'b10,
    CLK_DIV16 = 2'b11
  } clk_sel_t;

  // Stored TCR fields (load is a strobe and is not stored)
  typedef struct packed {
    logic     dw;
    logic     en;
    logic     clr;
    clk_sel_t sel;
  } tcr_t;

  // Terminal prescaler count for each divisor
  function automatic logic [PRE_W-1:0] div_last(input clk_sel_t sel);
    logic [PRE_W-1:0] last;
    case (sel)
      CLK_DIV2:  last = PRE_W'(1);
      CLK_DIV4:  last = PRE_W'(3);
      CLK_DIV8:  last = PRE_W'(7);
      default:   last = PRE_W'(15);
    endcase
    return last;
  endfunction

  // Byte lane extraction from a 32-bit little-endian word
  function automatic logic [7:0] byte_of(input logic [31:0] word, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler for the compare timer: emits a one-cycle tick every 2/4/8/16 clocks.
module timer_prescaler
  import timer_pkg::*;
(
  input  logic     pclk,
  input  logic     presetn,
  input  logic     en,
  input  clk_sel_t clk_sel,
  input  logic     restart,
  output logic     tick
);

  logic [PRE_W-1:0] pre;

  // Divide counter; held at zero while disabled or on restart
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      pre  <= '0;
      tick <= 1'b0;
    end else if (!en || restart) begin
      pre  <= '0;
      tick <= 1'b0;
    end else if (pre == div_last(clk_sel)) begin
      pre  <= '0;
      tick <= 1'b1;
    end else begin
      pre  <= pre + PRE_W'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/apb_timer_cmp.sv
// APB slave up/down timer with load, compare match/clear, status flags and
// maskable interrupt. Optional PWM output when TIMER_PWM_EN is defined.
module apb_timer_cmp
  import timer_pkg::*;
#(
  parameter int unsigned CNT_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [7:0]            pwdata,
  output logic [7:0]            prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic                  irq
`ifdef TIMER_PWM_EN
  ,
  output logic                  pwm_out
`endif
);

  localparam int unsigned NB = CNT_WIDTH / 8;

  tcr_t                 tcr, tcr_d;
  logic [2:0]           tsr, tsr_d, flag_set;
  logic [2:0]           tier, tier_d;
  logic [CNT_WIDTH-1:0] tdr, tdr_d, tcmp, tcmp_d, cnt, cnt_d;
  logic [23:0]          shadow, shadow_d;
  logic                 irq_d;
  logic [31:0]          cnt_ext;
  logic [7:0]           rd_data, tcr_rd;
  logic                 tick, step, load_c, restart_c;
`ifdef TIMER_PWM_EN
  logic                 pol, pol_d, pwm_d;
`endif

  // Address decode
  logic       acc, wr, rd, hi_zero, unmapped;
  logic       sel_tcr, sel_tsr, sel_tier, sel_tdr, sel_tcmp, sel_tcnt;
  logic [3:0] off;
  logic [1:0] lane;

  assign acc      = psel & penable;
  assign wr       = acc & pwrite;
  assign rd       = acc & ~pwrite;
  assign off      = paddr[3:0];
  assign lane     = off[1:0];
  assign hi_zero  = (paddr >> 4) == '0;
  assign sel_tcr  = hi_zero & (off == 4'(REG_TCR));
  assign sel_tsr  = hi_zero & (off == 4'(REG_TSR));
  assign sel_tier = hi_zero & (off == 4'(REG_TIER));
  assign sel_tdr  = hi_zero & (off[3:2] == 2'(REG_TDR >> 2));
  assign sel_tcmp = hi_zero & (off[3:2] == 2'(REG_TCMP >> 2));
  assign sel_tcnt = hi_zero & (off[3:2] == 2'(REG_TCNT >> 2));
  assign unmapped = ~hi_zero | (off == 4'd3);
  assign cnt_ext  = 32'(cnt);

  assign pready   = 1'b1;
  assign pslverr  = acc & (unmapped | (pwrite & sel_tcnt));
  assign prdata   = rd ? rd_data : 8'h00;

  timer_prescaler u_prescaler (
    .pclk    (pclk),
    .presetn (presetn),
    .en      (tcr.en),
    .clk_sel (tcr.sel),
    .restart (restart_c),
    .tick    (tick)
  );

`ifdef TIMER_PWM_EN
  assign tcr_rd = {1'b0, pol, tcr.dw, tcr.en, tcr.clr, 1'b0, tcr.sel};
`else
  assign tcr_rd = {2'b00, tcr.dw, tcr.en, tcr.clr, 1'b0, tcr.sel};
`endif

  // Read data mux; TCNT upper bytes come from the coherent-read shadow
  always_comb begin
    rd_data = 8'h00;
    if (hi_zero) begin
      case (off[3:2])
        2'd0: begin
          case (lane)
            2'd0:    rd_data = tcr_rd;
            2'd1:    rd_data = {5'b0, tsr};
            2'd2:    rd_data = {5'b0, tier};
            default: rd_data = 8'h00;
          endcase
        end
        2'd1:    rd_data = byte_of(32'(tdr), lane);
        2'd2:    rd_data = byte_of(32'(tcmp), lane);
        default: rd_data = (lane == 2'd0) ? cnt_ext[7:0] : byte_of({shadow, 8'h00}, lane);
      endcase
    end
  end

  // Next-state: counting, load, flags and register writes
  always_comb begin
    tcr_d     = tcr;
    tsr_d     = tsr;
    tier_d    = tier;
    tdr_d     = tdr;
    tcmp_d    = tcmp;
    cnt_d     = cnt;
    shadow_d  = shadow;
    flag_set  = '0;
    load_c    = wr & sel_tcr & pwdata[TCR_LOAD];
    restart_c = load_c | (wr & sel_tcr & (pwdata[1:0] != tcr.sel));
    step      = tick & tcr.en & ~load_c;
`ifdef TIMER_PWM_EN
    pol_d     = pol;
`endif

    if (step) begin
      if (cnt == tcmp) flag_set[TSR_CMP] = 1'b1;
      if (tcr.dw) begin
        if (cnt == '0) begin
          cnt_d             = '1;
          flag_set[TSR_UDF] = 1'b1;
        end else begin
          cnt_d = cnt - CNT_WIDTH'(1);
        end
      end else if (tcr.clr && (cnt == tcmp)) begin
        cnt_d = '0;
      end else if (cnt == '1) begin
        cnt_d             = '0;
        flag_set[TSR_OVF] = 1'b1;
      end else begin
        cnt_d = cnt + CNT_WIDTH'(1);
      end
    end
    if (load_c) cnt_d = tdr;

    if (wr && sel_tsr) tsr_d = (tsr & pwdata[2:0]) | flag_set;
    else               tsr_d = tsr | flag_set;

    if (wr && sel_tier) tier_d = pwdata[2:0];

    if (wr && sel_tcr) begin
      tcr_d.dw  = pwdata[TCR_DW];
      tcr_d.en  = pwdata[TCR_EN];
      tcr_d.clr = pwdata[TCR_CLR];
      tcr_d.sel = clk_sel_t'(pwdata[1:0]);
`ifdef TIMER_PWM_EN
      pol_d     = pwdata[TCR_POL];
`endif
    end

    for (int unsigned b = 0; b < NB; b++) begin
      if (wr && sel_tdr && (lane == 2'(b)))  tdr_d[8*b +: 8]  = pwdata;
      if (wr && sel_tcmp && (lane == 2'(b))) tcmp_d[8*b +: 8] = pwdata;
    end

    if (rd && sel_tcnt && (lane == 2'd0)) shadow_d = cnt_ext[31:8];

    irq_d = |(tsr_d & tier_d);
`ifdef TIMER_PWM_EN
    pwm_d = tcr_d.en & ((cnt_d < tcmp_d) ^ pol_d);
`endif
  end

  // State registers
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      tcr     <= '0;
      tsr     <= '0;
      tier    <= '0;
      tdr     <= '0;
      tcmp    <= '0;
      cnt     <= '0;
      shadow  <= '0;
      irq     <= 1'b0;
`ifdef TIMER_PWM_EN
      pol     <= 1'b0;
      pwm_out <= 1'b0;
`endif
    end else begin
      tcr     <= tcr_d;
      tsr     <= tsr_d;
      tier    <= tier_d;
      tdr     <= tdr_d;
      tcmp    <= tcmp_d;
      cnt     <= cnt_d;
      shadow  <= shadow_d;
      irq     <= irq_d;
`ifdef TIMER_PWM_EN
      pol     <= pol_d;
      pwm_out <= pwm_d;
`endif
    end
  end

endmodule

// File: tb/tb_apb_timer_cmp.sv
// Scoreboard bench for apb_timer_cmp (16-bit counter) against an
// event-scheduled reference model of the timer.
module tb_apb_timer_cmp;

  localparam int unsigned W    = 16;
  localparam int unsigned NB   = W / 8;
  localparam longint      MAXV = (longint'(1) << W) - 1;

  logic       clk = 1'b0;
  logic       presetn = 1'b0;
  logic       psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [7:0] paddr = 8'h00, pwdata = 8'h00;
  logic [7:0] prdata;
  logic       pready, pslverr, irq;
`ifdef TIMER_PWM_EN
  logic       pwm_out;
`endif

  apb_timer_cmp #(.CNT_WIDTH(W), .ADDR_WIDTH(8)) dut (
    .pclk    (clk),
    .presetn (presetn),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr),
    .irq     (irq)
`ifdef TIMER_PWM_EN
    ,
    .pwm_out (pwm_out)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
    logic       err;
    logic       irq;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: counter steps are scheduled at absolute edge numbers
  longint cyc = 0, next_step = -1;
  longint m_cnt = 0, m_tdr = 0, m_tcmp = 0, m_shadow = 0;
  bit     m_en = 0, m_dw = 0, m_clr = 0;
  int     m_sel = 0, m_tsr = 0, m_tier = 0;

  function automatic longint div_of(int s);
    return longint'(2) << s;
  endfunction

  function automatic logic [7:0] m_read(int a);
    int lane;
    lane = a % 4;
    if (a == 0)              return 8'((int'(m_dw) << 5) | (int'(m_en) << 4) | (int'(m_clr) << 3) | m_sel);
    if (a == 1)              return 8'(m_tsr);
    if (a == 2)              return 8'(m_tier);
    if (a >= 4 && a < 8)     return 8'((m_tdr >> (8 * lane)) & 255);
    if (a >= 8 && a < 12)    return 8'((m_tcmp >> (8 * lane)) & 255);
    if (a == 12)             return 8'(m_cnt & 255);
    if (a > 12 && a < 16)    return 8'((m_shadow >> (8 * (lane - 1))) & 255);
    return 8'h00;
  endfunction

  function automatic bit m_err(int a, bit wr);
    return (a == 3) || (a >= 16) || (wr && a >= 12 && a < 16);
  endfunction

  task automatic m_reset();
    m_cnt = 0; m_tdr = 0; m_tcmp = 0; m_shadow = 0;
    m_en = 0; m_dw = 0; m_clr = 0; m_sel = 0; m_tsr = 0; m_tier = 0;
    next_step = -1;
  endtask

  task automatic m_edge();
    bit     acc, wr, rd, load, new_en;
    int     a, d, lane, set, new_sel;
    longint nc;
    acc  = psel && penable;
    wr   = acc && pwrite;
    rd   = acc && !pwrite;
    a    = int'(paddr);
    d    = int'(pwdata);
    lane = a % 4;
    load = wr && (a == 0) && pwdata[7];
    set  = 0;
    nc   = m_cnt;
    if (m_en && next_step == cyc && !load) begin
      if (m_cnt == m_tcmp) set |= 4;
      if (m_dw) begin
        if (m_cnt == 0) begin nc = MAXV; set |= 2; end
        else nc = m_cnt - 1;
      end else if (m_clr && m_cnt == m_tcmp) nc = 0;
      else if (m_cnt == MAXV) begin nc = 0; set |= 1; end
      else nc = m_cnt + 1;
      next_step = cyc + div_of(m_sel);
    end
    if (rd && a == 12) m_shadow = m_cnt >> 8;
    if (wr && a == 1) m_tsr = m_tsr & d & 7;
    m_tsr |= set;
    if (wr && a == 2) m_tier = d & 7;
    if (wr && a >= 4 && a < 8 && lane < NB)
      m_tdr = (m_tdr & ~(longint'(255) << (8 * lane))) | (longint'(d) << (8 * lane));
    if (wr && a >= 8 && a < 12 && lane < NB)
      m_tcmp = (m_tcmp & ~(longint'(255) << (8 * lane))) | (longint'(d) << (8 * lane));
    if (wr && a == 0) begin
      new_en  = pwdata[4];
      new_sel = d & 3;
      if (!new_en) next_step = -1;
      else if (load || new_sel != m_sel || !m_en) next_step = cyc + div_of(new_sel) + 1;
      m_en  = new_en;
      m_dw  = pwdata[5];
      m_clr = pwdata[3];
      m_sel = new_sel;
    end
    if (load) nc = m_tdr;
    m_cnt = nc;
  endtask

  always @(posedge clk or negedge presetn) begin
    if (!presetn) m_reset();
    else begin
      m_edge();
      cyc++;
    end
  end

  function automatic void chk(string nm, logic [7:0] act, logic [7:0] exp, logic [7:0] a);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s addr=0x%02h: got 0x%02h expected 0x%02h at %0t", nm, a, act, exp, $time);
    end
  endfunction

  // Monitor: pop one expectation per access phase
  always @(negedge clk) begin
    if (presetn && psel && penable) begin
      if (sbq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_underflow: access at addr=0x%02h had no expectation", paddr);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("pready", 8'(pready), 8'h01, e.addr);
        chk("pslverr", 8'(pslverr), 8'(e.err), e.addr);
        chk("irq", 8'(irq), 8'(e.irq), e.addr);
        if (!e.wr) chk("prdata", prdata, e.data, e.addr);
      end
    end
  end

  task automatic apb(bit wr, logic [7:0] a, logic [7:0] d);
    exp_t e;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    e.wr   = wr;
    e.addr = a;
    e.data = wr ? 8'h00 : m_read(int'(a));
    e.err  = m_err(int'(a), wr);
    e.irq  = (m_tsr & m_tier) != 0;
    sbq.push_back(e);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic wr(logic [7:0] a, logic [7:0] d); apb(1'b1, a, d); endtask
  task automatic rd(logic [7:0] a); apb(1'b0, a, 8'h00); endtask
  task automatic idle(int n); repeat (n) @(posedge clk); endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a, d;
    idle(3); #3 presetn = 1'b1;

    // Reset values
    foreach (sbq[i]) ;
    for (int i = 0; i < 16; i++) rd(8'(i));

    // Overflow from a loaded value near the top
    wr(8'h04, 8'h00); wr(8'h05, 8'hFF); wr(8'h00, 8'h90);
    idle(400); rd(8'h01); rd(8'h0C); rd(8'h0D);
    idle(150); rd(8'h01); rd(8'h0C); rd(8'h0D);

    // Software clear: 0 clears, 1 has no effect
    wr(8'h01, 8'h00); rd(8'h01); wr(8'h01, 8'h01); rd(8'h01);

    // Down count through zero sets underflow
    wr(8'h00, 8'h00); wr(8'h04, 8'h05); wr(8'h05, 8'h00); wr(8'h00, 8'hB0);
    idle(16); rd(8'h01); rd(8'h0C); rd(8'h0D);

    // Compare match with clear and interrupt
    wr(8'h00, 8'h00); wr(8'h01, 8'h00); wr(8'h04, 8'h00);
    wr(8'h08, 8'h10); wr(8'h09, 8'h00); wr(8'h02, 8'h04); wr(8'h00, 8'h98);
    idle(20); rd(8'h01); rd(8'h0C);
    idle(20); rd(8'h01); rd(8'h0C); rd(8'h0D);
    for (int i = 0; i < 6; i++) rd(8'h0C);

    // Coherent multi-byte read across a carry
    wr(8'h00, 8'h00); wr(8'h01, 8'h00); wr(8'h04, 8'hFC); wr(8'h05, 8'h12); wr(8'h00, 8'h90);
    for (int i = 0; i < 6; i++) begin rd(8'h0C); rd(8'h0D); end
    rd(8'h0E); rd(8'h0F);

    // Error responses and ignored upper lanes
    wr(8'h0C, 8'h55); wr(8'h03, 8'h01); rd(8'h03); rd(8'h20); wr(8'h06, 8'hAA); rd(8'h06);

    // Asynchronous reset mid-count
    wr(8'h02, 8'h07); idle(30);
    @(posedge clk); #3 presetn = 1'b0;
    #200 presetn = 1'b1;
    rd(8'h00); rd(8'h01); rd(8'h02); rd(8'h04); rd(8'h0C);
    idle(40); rd(8'h0C);
    wr(8'h04, 8'hF0); wr(8'h05, 8'hFF); wr(8'h00, 8'h90);
    idle(40); rd(8'h01); rd(8'h0C);

    // Randomized traffic
    repeat (400) begin
      a = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
      d = 8'($urandom);
      if (a == 8'h00) begin
        d[1] = 1'b0;
        d[7] = ($urandom_range(0, 3) == 0);
      end
      if (a >= 8'h08 && a <= 8'h0B && a[0]) d = 8'h00;
      apb(1'($urandom_range(0, 1)), a, d);
      idle($urandom_range(0, 12));
    end

    idle(4);
    n_checks++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d expectations left, required 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
